// File: rtl/train_dispatch.sv
// train_dispatch: replays push/pop operations of the train-station stack
// problem and streams out the resulting departure order, or one error beat
// when the operation stream is illegal.
module train_dispatch #(
  parameter int MAX_CARS = 10,
  parameter int CW       = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic [CW-1:0] data,
  output logic          out_valid,
  output logic [CW-1:0] out_car,
  output logic          out_err
);

  localparam int            SPW  = $clog2(MAX_CARS + 1);
  localparam logic [CW-1:0] MAXC = CW'(MAX_CARS);

  typedef enum logic [1:0] {IDLE, LOAD, OUT, ERR} state_t;

  state_t         state;
  logic [CW-1:0]  n_cars;
  logic [CW:0]    next_car;
  logic [SPW-1:0] sp;
  logic [SPW-1:0] dcnt;
  logic [SPW-1:0] oidx;
  logic [4:0]     beat_cnt;
  logic           err;
  logic [CW-1:0]  stack [MAX_CARS];
  logic [CW-1:0]  dep   [MAX_CARS];

  // Control FSM, stack replay and registered output stream
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      n_cars    <= '0;
      next_car  <= '0;
      sp        <= '0;
      dcnt      <= '0;
      oidx      <= '0;
      beat_cnt  <= '0;
      err       <= 1'b0;
      out_valid <= 1'b0;
      out_car   <= '0;
      out_err   <= 1'b0;
      for (int unsigned i = 0; i < MAX_CARS; i++) begin
        stack[i] <= '0;
        dep[i]   <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          out_valid <= 1'b0;
          out_car   <= '0;
          out_err   <= 1'b0;
          if (in_valid) begin
            n_cars   <= data;
            next_car <= (CW+1)'(1);
            sp       <= '0;
            dcnt     <= '0;
            oidx     <= '0;
            beat_cnt <= '0;
            err      <= (data == '0) || (data > MAXC);
            state    <= LOAD;
          end
        end

        LOAD: begin
          if (in_valid) begin
            if (beat_cnt != 5'd31) beat_cnt <= beat_cnt + 5'd1;
            if (!err) begin
              if (data[0]) begin
                if (next_car > {1'b0, n_cars}) begin
                  err <= 1'b1;
                end else begin
                  stack[sp] <= next_car[CW-1:0];
                  sp        <= sp + 1'b1;
                  next_car  <= next_car + 1'b1;
                end
              end else begin
                if (sp == '0) begin
                  err <= 1'b1;
                end else begin
                  dep[dcnt] <= stack[sp - 1'b1];
                  sp        <= sp - 1'b1;
                  dcnt      <= dcnt + 1'b1;
                end
              end
            end
          end else begin
            out_valid <= 1'b1;
            if (!err && int'(beat_cnt) == 2 * int'(n_cars) && int'(dcnt) == int'(n_cars)) begin
              out_car <= dep[0];
              out_err <= 1'b0;
              oidx    <= SPW'(1);
              state   <= OUT;
            end else begin
              out_car <= '0;
              out_err <= 1'b1;
              state   <= ERR;
            end
          end
        end

        // in_valid is deliberately not looked at here or in ERR
        OUT: begin
          if (int'(oidx) == int'(n_cars)) begin
            out_valid <= 1'b0;
            out_car   <= '0;
            state     <= IDLE;
          end else begin
            out_car <= dep[oidx];
            oidx    <= oidx + 1'b1;
          end
        end

        ERR: begin
          out_valid <= 1'b0;
          out_err   <= 1'b0;
          out_car   <= '0;
          state     <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_train_dispatch.sv
// Self-checking bench for train_dispatch: directed scenarios plus randomized
// operation streams compared against a queue-based stack model.
module tb_train_dispatch;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic [CW-1:0] data = '0;
  logic          out_valid;
  logic [CW-1:0] out_car;
  logic          out_err;

  int n_tests = 0;
  int n_fail  = 0;

  bit ops[$];
  bit exp_err;
  int exp_cars[$];

  train_dispatch #(.MAX_CARS(10), .CW(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .data      (data),
    .out_valid (out_valid),
    .out_car   (out_car),
    .out_err   (out_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: plain stack simulation of the car-yard rules
  task automatic model(input int n);
    int stk[$];
    int next;
    next = 1;
    exp_cars = {};
    exp_err = (n == 0) || (n > 10);
    if (!exp_err) begin
      foreach (ops[i]) begin
        if (ops[i]) begin
          if (next > n) exp_err = 1'b1;
          else begin stk.push_back(next); next++; end
        end else begin
          if (stk.size() == 0) exp_err = 1'b1;
          else exp_cars.push_back(stk.pop_back());
        end
        if (exp_err) break;
      end
    end
    if (!exp_err && (ops.size() != 2 * n || exp_cars.size() != n)) exp_err = 1'b1;
  endtask

  // Drives one transaction and checks the resulting beats cycle by cycle.
  // pulse_at >= 0 pulses in_valid during that output beat.
  task automatic run_txn(input int n, input int pulse_at);
    logic [CW-1:0] r;
    model(n);
    @(negedge clk);
    in_valid = 1'b1;
    data = CW'(n);
    foreach (ops[i]) begin
      @(negedge clk);
      r = CW'($urandom);
      r[0] = ops[i];
      data = r;
    end
    @(negedge clk);
    in_valid = 1'b0;
    data = CW'($urandom);
    @(negedge clk);
    if (exp_err) begin
      check("err_valid", out_valid, 1);
      check("err_flag", out_err, 1);
      check("err_car", out_car, 0);
    end else begin
      for (int i = 0; i < n; i++) begin
        if (i > 0) @(negedge clk);
        in_valid = (i == pulse_at);
        data = CW'($urandom);
        check("out_valid", out_valid, 1);
        check("out_err", out_err, 0);
        check("out_car", out_car, exp_cars[i]);
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    check("idle_valid", out_valid, 0);
    check("idle_car", out_car, 0);
    check("idle_err", out_err, 0);
  endtask

  task automatic gen_legal(input int n);
    int pushed;
    int depth;
    pushed = 0;
    depth = 0;
    ops = {};
    for (int i = 0; i < 2 * n; i++) begin
      if (pushed < n && (depth == 0 || $urandom_range(0, 1) == 1)) begin
        ops.push_back(1'b1); pushed++; depth++;
      end else begin
        ops.push_back(1'b0); depth--;
      end
    end
  endtask

  initial begin
    int n;
    int mode;
    int len;
    repeat (2) @(negedge clk);
    check("rst_valid", out_valid, 0);
    check("rst_car", out_car, 0);
    check("rst_err", out_err, 0);
    rst_n = 1'b1;

    ops = {1, 0, 1, 0, 1, 0};                run_txn(3, -1);
    ops = {1, 1, 0, 1, 0, 0, 1, 0};          run_txn(4, -1);
    ops = {1, 0};                            run_txn(1, -1);
    ops = {};
    for (int i = 0; i < 10; i++) ops.push_back(1'b1);
    for (int i = 0; i < 10; i++) ops.push_back(1'b0);
    run_txn(10, -1);
    ops = {0, 1, 1, 0};                      run_txn(2, -1);
    ops = {1, 1};                            run_txn(1, -1);
    ops = {1, 1, 0};                         run_txn(2, -1);
    ops = {1, 0};                            run_txn(0, -1);
    ops = {1, 0, 1, 0};                      run_txn(11, -1);
    ops = {};                                run_txn(2, -1);

    // abort mid-LOAD via reset
    @(negedge clk);
    in_valid = 1'b1;
    data = CW'(5);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      data = CW'(i % 2 == 0 ? 1 : 0);
    end
    @(negedge clk);
    rst_n = 1'b0;
    in_valid = 1'b0;
    #1;
    check("abort_valid", out_valid, 0);
    check("abort_car", out_car, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check("post_abort_quiet", out_valid, 0);
    end
    ops = {1, 1, 0, 0};                      run_txn(2, -1);

    // in_valid pulsed during output must not disturb the stream
    ops = {1, 0, 1, 0, 1, 0};                run_txn(3, 1);
    ops = {1, 1, 0, 0};                      run_txn(2, -1);

    for (int t = 0; t < 60; t++) begin
      n = $urandom_range(0, 12);
      mode = $urandom_range(0, 4);
      gen_legal(n > 10 ? 10 : n);
      if (mode == 3) begin
        len = $urandom_range(0, 2 * n + 2);
        ops = {};
        for (int i = 0; i < len; i++) ops.push_back(1'($urandom));
      end else if (mode == 4) begin
        if (ops.size() > 0 && $urandom_range(0, 1) == 1) void'(ops.pop_back());
        else ops.push_back(1'($urandom));
      end
      run_txn(n, ($urandom_range(0, 3) == 0) ? $urandom_range(0, 9) : -1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
